// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Holds one decoded instruction for the execute stage. When a load in EX
// writes a register that the instruction in ID reads, ID is held and a bubble
// goes into EX. Flush kills both the held and the incoming instruction.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_id_*                  decode-stage instruction and valid
//   o_id_ready              decode instruction is accepted this cycle
//   i_ex_ready              execute stage consumes the held instruction
//   i_flush                 kill held and incoming instruction
//   o_ex_*                  registered instruction presented to execute
//   o_load_use_stall        combinational load-use hazard indication
//   o_bubble_cnt            saturating count of inserted load-use bubbles
module id_ex_stage #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    output logic             o_id_ready,
    input  logic [15:0]      i_id_ctrl,
    input  logic [6:0]       i_id_opcode,
    input  logic [2:0]       i_id_funct3,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic [4:0]       i_id_rd,
    input  logic [31:0]      i_id_pc,
    input  logic [31:0]      i_id_rs1_data,
    input  logic [31:0]      i_id_rs2_data,
    input  logic [31:0]      i_id_imm,
    input  logic             i_ex_ready,
    input  logic             i_flush,
    output logic             o_ex_valid,
    output logic [15:0]      o_ex_ctrl,
    output logic [6:0]       o_ex_opcode,
    output logic [2:0]       o_ex_funct3,
    output logic [4:0]       o_ex_rs1,
    output logic [4:0]       o_ex_rs2,
    output logic [4:0]       o_ex_rd,
    output logic [31:0]      o_ex_pc,
    output logic [31:0]      o_ex_rs1_data,
    output logic [31:0]      o_ex_rs2_data,
    output logic [31:0]      o_ex_imm,
    output logic             o_load_use_stall,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    // Bit position of mem_read_en inside the packed control word.
    localparam int unsigned MemReadBit = 4;

    logic             r_ex_valid;
    logic [15:0]      r_ex_ctrl;
    logic [6:0]       r_ex_opcode;
    logic [2:0]       r_ex_funct3;
    logic [4:0]       r_ex_rs1;
    logic [4:0]       r_ex_rs2;
    logic [4:0]       r_ex_rd;
    logic [31:0]      r_ex_pc;
    logic [31:0]      r_ex_rs1_data;
    logic [31:0]      r_ex_rs2_data;
    logic [31:0]      r_ex_imm;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_uses_rs1;
    logic w_uses_rs2;
    logic w_load_use_stall;
    logic w_advance;

    // Source-register usage by opcode; system and unknown opcodes read nothing.
    always_comb begin
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (i_id_opcode)
            7'b0110011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            7'b0100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            7'b1100011: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            7'b0010011: w_uses_rs1 = 1'b1;
            7'b0000011: w_uses_rs1 = 1'b1;
            7'b1100111: w_uses_rs1 = 1'b1;
            default: begin
                w_uses_rs1 = 1'b0;
                w_uses_rs2 = 1'b0;
            end
        endcase
    end

    // x0 is never written, so a load targeting it cannot create a hazard.
    assign w_load_use_stall = i_id_valid & r_ex_valid & r_ex_ctrl[MemReadBit]
                              & (r_ex_rd != 5'd0)
                              & ((w_uses_rs1 & (i_id_rs1 == r_ex_rd))
                                 | (w_uses_rs2 & (i_id_rs2 == r_ex_rd)));

    assign w_advance = ~r_ex_valid | i_ex_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_ctrl     <= '0;
            r_ex_opcode   <= '0;
            r_ex_funct3   <= '0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_pc       <= '0;
            r_ex_rs1_data <= '0;
            r_ex_rs2_data <= '0;
            r_ex_imm      <= '0;
            r_bubble_cnt  <= '0;
        end else if (i_flush) begin
            // Payload is left as-is; zero ctrl is what makes the slot harmless.
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= '0;
        end else if (w_advance) begin
            if (i_id_valid && !w_load_use_stall) begin
                r_ex_valid    <= 1'b1;
                r_ex_ctrl     <= i_id_ctrl;
                r_ex_opcode   <= i_id_opcode;
                r_ex_funct3   <= i_id_funct3;
                r_ex_rs1      <= i_id_rs1;
                r_ex_rs2      <= i_id_rs2;
                r_ex_rd       <= i_id_rd;
                r_ex_pc       <= i_id_pc;
                r_ex_rs1_data <= i_id_rs1_data;
                r_ex_rs2_data <= i_id_rs2_data;
                r_ex_imm      <= i_id_imm;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= '0;
            end
            if (w_load_use_stall && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign o_id_ready       = w_advance & ~w_load_use_stall & ~i_flush;
    assign o_load_use_stall = w_load_use_stall;
    assign o_ex_valid       = r_ex_valid;
    assign o_ex_ctrl        = r_ex_ctrl;
    assign o_ex_opcode      = r_ex_opcode;
    assign o_ex_funct3      = r_ex_funct3;
    assign o_ex_rs1         = r_ex_rs1;
    assign o_ex_rs2         = r_ex_rs2;
    assign o_ex_rd          = r_ex_rd;
    assign o_ex_pc          = r_ex_pc;
    assign o_ex_rs1_data    = r_ex_rs1_data;
    assign o_ex_rs2_data    = r_ex_rs2_data;
    assign o_ex_imm         = r_ex_imm;
    assign o_bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam logic [6:0] OpAdd   = 7'b0110011;
    localparam logic [6:0] OpAddi  = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpSys   = 7'b1110011;
    localparam logic [15:0] CtrlAdd = 16'h8500;
    localparam logic [15:0] CtrlLw  = 16'hA030;  // reg_write, mem_to_reg=01, src_b=imm, mem_read
    localparam logic [15:0] CtrlSw  = 16'h0028;  // src_b=imm, mem_write

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [15:0] id_ctrl;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic        ex_ready;
    logic        flush;

    logic        id_ready, ex_valid, load_use_stall;
    logic [15:0] ex_ctrl;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [15:0] bubble_cnt;

    // Outputs of the narrow-counter instance (same stimulus).
    logic        s_id_ready, s_ex_valid, s_load_use_stall;
    logic [15:0] s_ex_ctrl;
    logic [6:0]  s_ex_opcode;
    logic [2:0]  s_ex_funct3;
    logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
    logic [31:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
    logic [1:0]  s_bubble_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_ctrl(id_ctrl), .i_id_opcode(id_opcode), .i_id_funct3(id_funct3),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd), .i_id_pc(id_pc),
        .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
        .i_ex_ready(ex_ready), .i_flush(flush), .o_ex_valid(ex_valid), .o_ex_ctrl(ex_ctrl),
        .o_ex_opcode(ex_opcode), .o_ex_funct3(ex_funct3), .o_ex_rs1(ex_rs1),
        .o_ex_rs2(ex_rs2), .o_ex_rd(ex_rd), .o_ex_pc(ex_pc), .o_ex_rs1_data(ex_rs1_data),
        .o_ex_rs2_data(ex_rs2_data), .o_ex_imm(ex_imm), .o_load_use_stall(load_use_stall),
        .o_bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CNT_W(2)) u_dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .o_id_ready(s_id_ready),
        .i_id_ctrl(id_ctrl), .i_id_opcode(id_opcode), .i_id_funct3(id_funct3),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rd(id_rd), .i_id_pc(id_pc),
        .i_id_rs1_data(id_rs1_data), .i_id_rs2_data(id_rs2_data), .i_id_imm(id_imm),
        .i_ex_ready(ex_ready), .i_flush(flush), .o_ex_valid(s_ex_valid),
        .o_ex_ctrl(s_ex_ctrl), .o_ex_opcode(s_ex_opcode), .o_ex_funct3(s_ex_funct3),
        .o_ex_rs1(s_ex_rs1), .o_ex_rs2(s_ex_rs2), .o_ex_rd(s_ex_rd), .o_ex_pc(s_ex_pc),
        .o_ex_rs1_data(s_ex_rs1_data), .o_ex_rs2_data(s_ex_rs2_data), .o_ex_imm(s_ex_imm),
        .o_load_use_stall(s_load_use_stall), .o_bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in ID; data fields are derived from the PC.
    task automatic drive(input logic [15:0] ctrl, input logic [6:0] opc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] pc);
        id_valid    = 1'b1;
        id_ctrl     = ctrl;
        id_opcode   = opc;
        id_funct3   = 3'd2;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_pc       = pc;
        id_rs1_data = pc + 32'd1;
        id_rs2_data = pc + 32'd2;
        id_imm      = pc + 32'd3;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_ctrl = '0; id_opcode = '0; id_funct3 = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_pc = '0; id_rs1_data = '0;
        id_rs2_data = '0; id_imm = '0; ex_ready = 1'b1; flush = 1'b0;
        #2;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_bubble", bubble_cnt, 0);
        chk("rst_id_ready", id_ready, 1);
        rst_n = 1'b1;

        // ADD x3,x1,x2: one-cycle capture.
        drive(CtrlAdd, OpAdd, 5'd1, 5'd2, 5'd3, 32'h100);
        chk("add_id_ready", id_ready, 1);
        tick();
        chk("add_ex_valid", ex_valid, 1);
        chk("add_ex_rd", ex_rd, 3);
        chk("add_ex_ctrl", ex_ctrl, CtrlAdd);
        chk("add_ex_rs1_data", ex_rs1_data, 32'h101);
        chk("add_ex_imm", ex_imm, 32'h103);
        chk("add_id_ready_after", id_ready, 1);

        // LW x5 then dependent ADD x6,x5,x1.
        drive(CtrlLw, OpLoad, 5'd1, 5'd7, 5'd5, 32'h104);
        tick();
        chk("lw_ex_ctrl", ex_ctrl, CtrlLw);
        drive(CtrlAdd, OpAdd, 5'd5, 5'd1, 5'd6, 32'h108);
        chk("lu_stall", load_use_stall, 1);
        chk("lu_id_ready", id_ready, 0);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_bubble_ctrl", ex_ctrl, 0);
        chk("lu_bubble_cnt", bubble_cnt, 1);
        chk("lu_payload_held", ex_pc, 32'h104);
        chk("lu_id_ready_after", id_ready, 1);
        tick();
        chk("lu_capture_valid", ex_valid, 1);
        chk("lu_capture_rd", ex_rd, 6);
        chk("lu_capture_pc", ex_pc, 32'h108);

        // Load to x0 never stalls.
        drive(CtrlLw, OpLoad, 5'd2, 5'd0, 5'd0, 32'h10C);
        tick();
        drive(CtrlAdd, OpAdd, 5'd0, 5'd0, 5'd7, 32'h110);
        chk("x0_stall", load_use_stall, 0);
        chk("x0_id_ready", id_ready, 1);
        tick();
        chk("x0_ex_rd", ex_rd, 7);
        chk("x0_bubble_cnt", bubble_cnt, 1);

        // Source-usage decode: ADDI ignores rs2, system op ignores both, store uses rs2.
        drive(CtrlLw, OpLoad, 5'd1, 5'd0, 5'd9, 32'h114);
        tick();
        drive(16'h8000, OpAddi, 5'd1, 5'd9, 5'd8, 32'h118);
        chk("addi_rs2_stall", load_use_stall, 0);
        drive(16'h0000, OpSys, 5'd9, 5'd9, 5'd0, 32'h118);
        chk("sys_stall", load_use_stall, 0);
        drive(CtrlSw, OpStore, 5'd2, 5'd9, 5'd0, 32'h11C);
        chk("sw_rs2_stall", load_use_stall, 1);
        tick();
        chk("sw_bubble_cnt", bubble_cnt, 2);
        chk("sw_bubble_opcode", ex_opcode, OpLoad);
        tick();
        chk("sw_capture_opcode", ex_opcode, OpStore);
        chk("sw_capture_ctrl", ex_ctrl, CtrlSw);

        // EX back-pressure for three cycles.
        ex_ready = 1'b0;
        drive(CtrlAdd, OpAdd, 5'd1, 5'd2, 5'd10, 32'h120);
        chk("bp_id_ready", id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_pc", ex_pc, 32'h11C);
            chk("bp_hold_valid", ex_valid, 1);
            chk("bp_hold_id_ready", id_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_ready", id_ready, 1);
        tick();
        chk("bp_capture_rd", ex_rd, 10);
        chk("bp_capture_pc", ex_pc, 32'h120);

        // Flush wins over hazard and back-pressure.
        drive(CtrlLw, OpLoad, 5'd1, 5'd0, 5'd11, 32'h124);
        tick();
        ex_ready = 1'b0;
        flush = 1'b1;
        drive(CtrlAdd, OpAdd, 5'd11, 5'd2, 5'd12, 32'h128);
        chk("fl_stall", load_use_stall, 1);
        chk("fl_id_ready", id_ready, 0);
        tick();
        chk("fl_ex_valid", ex_valid, 0);
        chk("fl_ex_ctrl", ex_ctrl, 0);
        chk("fl_bubble_cnt", bubble_cnt, 2);
        chk("fl_payload_pc", ex_pc, 32'h124);
        flush = 1'b0;
        ex_ready = 1'b1;

        // Three more bubbles: wide counter reaches 5, 2-bit counter saturates at 3.
        for (int i = 0; i < 3; i++) begin
            drive(CtrlLw, OpLoad, 5'd1, 5'd0, 5'd13, 32'h200 + 32'(i * 8));
            tick();
            drive(CtrlAdd, OpAdd, 5'd13, 5'd2, 5'd14, 32'h204 + 32'(i * 8));
            tick();
            chk("sat_wide_cnt", bubble_cnt, 32'(3 + i));
            chk("sat_narrow_cnt", s_bubble_cnt, 3);
        end
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        chk("pre_rst_rd", ex_rd, 14);

        // Asynchronous reset mid-stream, checked well before the next edge.
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", ex_valid, 0);
        chk("arst_ex_ctrl", ex_ctrl, 0);
        chk("arst_ex_rd", ex_rd, 0);
        chk("arst_ex_pc", ex_pc, 0);
        chk("arst_ex_imm", ex_imm, 0);
        chk("arst_bubble", bubble_cnt, 0);
        chk("arst_narrow_bubble", s_bubble_cnt, 0);
        rst_n = 1'b1;
        id_valid = 1'b0;
        tick();
        chk("post_rst_idle", ex_valid, 0);
        drive(CtrlAdd, OpAdd, 5'd1, 5'd2, 5'd3, 32'h300);
        tick();
        chk("post_rst_capture", ex_valid, 1);
        chk("post_rst_pc", ex_pc, 32'h300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter CNT_W, default 16, width of the load-use bubble counter.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_valid  in  1  decode stage holds a valid instruction.
REQ-005 id_ready  out  1  stage accepts the decode instruction this cycle.
REQ-006 id_ctrl  in  16  packed decode controls {reg_write_en, mem_to_reg[1:0], alu_op[3:0], alu_src_a[1:0], alu_src_b[1:0], mem_read_en, mem_write_en, branch, jump, jalr}, MSB first.
REQ-007 id_opcode  in  7  instruction opcode, used for hazard source-usage decode.
REQ-008 id_funct3  in  3  funct3 field.
REQ-009 id_rs1, id_rs2, id_rd  in  5 each  register addresses.
REQ-010 id_pc, id_rs1_data, id_rs2_data, id_imm  in  32 each  PC, register-file read data, sign-extended immediate.
REQ-011 ex_ready  in  1  execute stage consumes the held instruction this cycle.
REQ-012 flush  in  1  kill held and incoming instruction (taken branch/jump).
REQ-013 ex_valid  out  1  held instruction is valid.
REQ-014 ex_ctrl  out  16  registered controls, same packing as id_ctrl.
REQ-015 ex_opcode 7, ex_funct3 3, ex_rs1/ex_rs2/ex_rd 5, ex_pc/ex_rs1_data/ex_rs2_data/ex_imm 32  out  registered payload.
REQ-016 load_use_stall  out  1  combinational load-use hazard indication.
REQ-017 bubble_cnt  out  CNT_W  count of inserted load-use bubbles.

Function
REQ-018 uses_rs1 SHALL be 1 for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111; else 0.
REQ-019 uses_rs2 SHALL be 1 for opcodes 0110011, 0100011, 1100011; else 0.
REQ-020 load_use_stall SHALL = id_valid & ex_valid & ex_ctrl.mem_read_en & (ex_rd != 0) & ((uses_rs1 & id_rs1 == ex_rd) | (uses_rs2 & id_rs2 == ex_rd)).
REQ-021 advance SHALL = ~ex_valid | ex_ready; id_ready SHALL = advance & ~load_use_stall & ~flush.
REQ-022 Priority per edge: flush > advance > hold.
REQ-023 flush: ex_valid <= 0, ex_ctrl <= 0, payload unchanged, incoming instruction dropped regardless of ex_ready/hazard.
REQ-024 advance with id_valid & ~load_use_stall: capture all id_* fields, ex_valid <= 1; latency one cycle.
REQ-025 advance with ~id_valid or load_use_stall: insert bubble, ex_valid <= 0, ex_ctrl <= 0, payload unchanged.
REQ-026 ~advance and ~flush: all outputs hold; decode instruction not accepted.
REQ-027 When ex_valid = 0, ex_ctrl SHALL be all-zero (no write, no memory access, no branch/jump).
REQ-028 bubble_cnt SHALL increment by 1 on each edge where advance & load_use_stall & ~flush; saturate at all-ones.
REQ-029 Opcode 1110011 and unknown opcodes SHALL pass through unmodified (uses_rs1 = uses_rs2 = 0).
REQ-030 A load with ex_rd = 0 SHALL never cause a stall.

Reset
REQ-031 rst_n low SHALL immediately clear ex_valid, ex_ctrl, all payload outputs, and bubble_cnt to 0, independent of clk.
REQ-032 First capture after rst_n rises occurs on the first rising edge with id_valid & id_ready.

Verification
REQ-033 ADD x3,x1,x2 (id_ctrl=16'h8500-equivalent, rd=3), ex_ready=1 -> next cycle ex_valid=1, ex_rd=3, ex_ctrl equals id_ctrl, id_ready stays 1.
REQ-034 LW x5 held in EX, then ADD x6,x5,x1 in ID, ex_ready=1 -> load_use_stall=1, id_ready=0; next cycle ex_valid=0, ex_ctrl=0, bubble_cnt=1; following cycle ADD captured.
REQ-035 LW x0 in EX, ID uses rs1=0 -> load_use_stall=0, no bubble, bubble_cnt unchanged.
REQ-036 ex_ready=0 for 3 cycles with valid instruction held -> outputs constant, id_ready=0; ex_ready=1 -> next ID instruction captured.
REQ-037 flush=1 together with id_valid=1, load_use_stall=1, ex_ready=0 -> next cycle ex_valid=0, ex_ctrl=0, bubble_cnt unchanged.
REQ-038 rst_n pulsed low mid-stream with ex_valid=1, bubble_cnt=5 -> outputs 0 before next clk edge; CNT_W=2 run of 4 bubbles -> bubble_cnt saturates at 3.
